// File: rtl/goldcrest_pkg.sv
// rtl/goldcrest_pkg.sv - shared types and constants for the goldcrest accumulator core
//   DATA_W / ADDR_W / MEM_DEPTH : datapath, address and memory sizes
//   UIO_OE                      : fixed bidirectional output-enable pattern
//   UIO_PROG / UIO_WR / UIO_HALTED : uio pin bit positions
//   opcode_t                    : instruction opcode field [7:4]
package goldcrest_pkg;

   localparam int DATA_W    = 8;
   localparam int ADDR_W    = 4;
   localparam int MEM_DEPTH = 16;

   localparam logic [7:0] UIO_OE = 8'h4F;

   localparam int UIO_PROG   = 4;
   localparam int UIO_WR     = 5;
   localparam int UIO_HALTED = 6;

   typedef enum logic [3:0] {
      OP_NOP = 4'h0,
      OP_LDI = 4'h1,
      OP_LD  = 4'h2,
      OP_ST  = 4'h3,
      OP_ADD = 4'h4,
      OP_SUB = 4'h5,
      OP_AND = 4'h6,
      OP_OR  = 4'h7,
      OP_XOR = 4'h8,
      OP_SHL = 4'h9,
      OP_SHR = 4'hA,
      OP_JMP = 4'hB,
      OP_JZ  = 4'hC,
      OP_JC  = 4'hD,
      OP_OUT = 4'hE,
      OP_HLT = 4'hF
   } opcode_t;

endpackage

// File: rtl/goldcrest_alu.sv
// rtl/goldcrest_alu.sv - combinational ALU producing the next accumulator and carry
//   opcode    : current instruction opcode
//   acc       : accumulator value before the instruction
//   operand   : immediate (LDI) or mem[n] (all other ops)
//   carry     : carry flag before the instruction
//   result    : accumulator value after the instruction
//   carry_out : carry flag after the instruction
module goldcrest_alu
   import goldcrest_pkg::*;
(
   input  opcode_t           opcode,
   input  logic [DATA_W-1:0] acc,
   input  logic [DATA_W-1:0] operand,
   input  logic              carry,
   output logic [DATA_W-1:0] result,
   output logic              carry_out
);

   logic [DATA_W:0] wide;

   always_comb begin
      // Opcodes that do not touch acc/C fall through with both unchanged.
      result    = acc;
      carry_out = carry;
      wide      = '0;
      case (opcode)
         OP_LDI, OP_LD: result = operand;
         OP_ADD: begin
            wide      = {1'b0, acc} + {1'b0, operand};
            result    = wide[DATA_W-1:0];
            carry_out = wide[DATA_W];
         end
         OP_SUB: begin
            // The ninth bit of a zero-extended subtraction is the borrow.
            wide      = {1'b0, acc} - {1'b0, operand};
            result    = wide[DATA_W-1:0];
            carry_out = wide[DATA_W];
         end
         OP_AND: result = acc & operand;
         OP_OR:  result = acc | operand;
         OP_XOR: result = acc ^ operand;
         OP_SHL: begin
            carry_out = acc[DATA_W-1];
            result    = {acc[DATA_W-2:0], 1'b0};
         end
         OP_SHR: begin
            carry_out = acc[0];
            result    = {1'b0, acc[DATA_W-1:1]};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/froith_goldcrest.sv
// rtl/froith_goldcrest.sv - 8-bit accumulator microcontroller tile with 16-byte program/data memory
//   clk, rst_n : clock, synchronous active-low reset
//   ena        : tile enable (unused)
//   ui_in      : program-load data byte
//   uo_out     : OUT register (or mem[wptr] in program mode when GOLDCREST_READBACK_EN is defined)
//   uio_in     : bit4 PROG, bit5 WR strobe
//   uio_out    : bits[3:0] PC, bit6 HALTED
//   uio_oe     : constant output-enable pattern
// Optional macro: GOLDCREST_READBACK_EN
module froith_goldcrest
   import goldcrest_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic [DATA_W-1:0] mem [MEM_DEPTH];

   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] out_reg;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] wptr;
   logic              carry;
   logic              halted;
   logic              wr_prev;
   logic              prog_prev;

   logic              prog;
   logic              wr;
   logic              prog_rise;
   logic              prog_fall;
   logic              wr_edge;

   logic [DATA_W-1:0] instr;
   opcode_t           opcode;
   logic [ADDR_W-1:0] n;
   logic [DATA_W-1:0] alu_operand;
   logic [DATA_W-1:0] alu_result;
   logic              alu_carry;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] pc_next;

   logic              unused;
   assign unused = &{1'b0, ena, uio_in[7:6], uio_in[3:0]};

   assign prog      = uio_in[UIO_PROG];
   assign wr        = uio_in[UIO_WR];
   assign prog_rise = prog & ~prog_prev;
   assign prog_fall = ~prog & prog_prev;
   assign wr_edge   = wr & ~wr_prev;

   assign instr  = mem[pc];
   assign opcode = opcode_t'(instr[DATA_W-1:ADDR_W]);
   assign n      = instr[ADDR_W-1:0];

   assign alu_operand = (opcode == OP_LDI) ? {{(DATA_W-ADDR_W){1'b0}}, n} : mem[n];

   goldcrest_alu u_alu (
      .opcode    (opcode),
      .acc       (acc),
      .operand   (alu_operand),
      .carry     (carry),
      .result    (alu_result),
      .carry_out (alu_carry)
   );

   assign pc_inc = pc + ADDR_W'(1);

   always_comb begin
      pc_next = pc_inc;
      case (opcode)
         OP_JMP:  pc_next = n;
         OP_JZ:   pc_next = (acc == '0) ? n : pc_inc;
         OP_JC:   pc_next = carry ? n : pc_inc;
         OP_HLT:  pc_next = pc;
         default: pc_next = pc_inc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc       <= '0;
         out_reg   <= '0;
         pc        <= '0;
         carry     <= 1'b0;
         halted    <= 1'b0;
         wptr      <= '0;
         wr_prev   <= 1'b0;
         prog_prev <= 1'b0;
         for (int i = 0; i < MEM_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         wr_prev   <= wr;
         prog_prev <= prog;
         if (prog) begin
            // The entry cycle only rewinds the pointer; a WR already high
            // at that point (e.g. held through reset) must not load a byte.
            if (prog_rise) begin
               wptr <= '0;
            end else if (wr_edge) begin
               mem[wptr] <= ui_in;
               wptr      <= wptr + ADDR_W'(1);
            end
         end else if (prog_fall) begin
            pc     <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            halted <= 1'b0;
         end else if (!halted) begin
            acc   <= alu_result;
            carry <= alu_carry;
            pc    <= pc_next;
            if (opcode == OP_ST) begin
               mem[n] <= acc;
            end
            if (opcode == OP_OUT) begin
               out_reg <= acc;
            end
            if (opcode == OP_HLT) begin
               halted <= 1'b1;
            end
         end
      end
   end

`ifdef GOLDCREST_READBACK_EN
   assign uo_out = prog ? mem[wptr] : out_reg;
`else
   assign uo_out = out_reg;
`endif

   always_comb begin
      uio_out             = '0;
      uio_out[ADDR_W-1:0] = pc;
      uio_out[UIO_HALTED] = halted;
   end

   assign uio_oe = UIO_OE;

endmodule

// File: tb/tb_froith_goldcrest.sv
// tb/tb_froith_goldcrest.sv - randomized model-checked bench for froith_goldcrest
module tb_froith_goldcrest;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int pass_cnt  = 0;
   int total_cnt = 0;

   int m_mem [16];
   int m_acc, m_c, m_pc, m_halted, m_out, m_wptr, m_wrp, m_progp;
   bit m_valid = 0;

   froith_goldcrest dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
   endtask

   task automatic model_exec();
      int ins, op, nn, v, npc, s;
      ins = m_mem[m_pc];
      op  = ins / 16;
      nn  = ins % 16;
      v   = m_mem[nn];
      npc = (m_pc + 1) % 16;
      case (op)
         1:  m_acc = nn;
         2:  m_acc = v;
         3:  m_mem[nn] = m_acc;
         4:  begin s = m_acc + v; m_c = (s > 255) ? 1 : 0; m_acc = s % 256; end
         5:  begin m_c = (m_acc < v) ? 1 : 0; m_acc = (m_acc - v + 256) % 256; end
         6:  m_acc = m_acc & v;
         7:  m_acc = m_acc | v;
         8:  m_acc = m_acc ^ v;
         9:  begin m_c = m_acc / 128; m_acc = (m_acc * 2) % 256; end
         10: begin m_c = m_acc % 2; m_acc = m_acc / 2; end
         11: npc = nn;
         12: if (m_acc == 0) npc = nn;
         13: if (m_c == 1) npc = nn;
         14: m_out = m_acc;
         15: begin m_halted = 1; npc = m_pc; end
         default: ;
      endcase
      m_pc = npc;
   endtask

   task automatic model_tick(input bit r, input bit p, input bit w, input int d);
      if (!r) begin
         for (int i = 0; i < 16; i++) m_mem[i] = 0;
         m_acc = 0; m_c = 0; m_pc = 0; m_halted = 0; m_out = 0;
         m_wptr = 0; m_wrp = 0; m_progp = 0;
         m_valid = 1;
      end else begin
         if (p) begin
            if (!m_progp) m_wptr = 0;
            else if (w && !m_wrp) begin
               m_mem[m_wptr] = d;
               m_wptr = (m_wptr + 1) % 16;
            end
         end else if (m_progp) begin
            m_pc = 0; m_acc = 0; m_c = 0; m_halted = 0;
         end else if (m_halted == 0) begin
            model_exec();
         end
         m_wrp   = w ? 1 : 0;
         m_progp = p ? 1 : 0;
      end
   endtask

   always @(negedge clk) begin
      logic [7:0] e_uo;
      if (m_valid) begin
`ifdef GOLDCREST_READBACK_EN
         e_uo = uio_in[4] ? 8'(m_mem[m_wptr]) : 8'(m_out);
`else
         e_uo = 8'(m_out);
`endif
         check("uo_out", uo_out, e_uo);
         check("uio_out", uio_out, 8'(m_halted * 64 + m_pc));
         check("uio_oe", uio_oe, 8'h4F);
      end
   end

   task automatic cycle(input bit r, input bit p, input bit w, input logic [7:0] d);
      logic [7:0] j;
      #1;
      j      = 8'($urandom);
      rst_n  = r;
      ui_in  = d;
      uio_in = {j[7:6], w, p, j[3:0]};
      ena    = j[5];
      @(posedge clk);
      model_tick(r, p, w, int'(d));
      @(negedge clk);
   endtask

   task automatic run(input int cycles);
      repeat (cycles) cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
   endtask

   // Bytes are listed first-to-last in the low 8*cnt bits of v.
   task automatic load(input logic [127:0] v, input int cnt);
      logic [7:0] b;
      cycle(1'b1, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < cnt; i++) begin
         b = v[8*(cnt-1-i) +: 8];
         cycle(1'b1, 1'b1, 1'b0, b);
         cycle(1'b1, 1'b1, 1'b1, b);
      end
      cycle(1'b1, 1'b1, 1'b0, 8'h00);
      cycle(1'b1, 1'b0, 1'b0, 8'h00);
   endtask

   localparam logic [127:0] PROG_A  = {8'h15, 8'h3E, 8'h4E, 8'hE0, 8'hF0};
   localparam logic [127:0] PROG_CD = {8'h11, 8'h3F, 8'h13, 8'hE0, 8'h5F, 8'hC7, 8'hB3, 8'hE0, 8'hF0};
   localparam logic [127:0] PROG_CY = {8'h1F, 8'h3F, 8'h90, 8'h90, 8'h90, 8'h90,
                                       8'h4F, 8'h4F, 8'hDA, 8'hF0, 8'hE0, 8'hF0};

   initial begin
      logic [7:0] seq [$];
      logic [7:0] last;
      logic [127:0] rp;
      bit p;

      rst_n = 1'b0; ena = 1'b0; ui_in = '0; uio_in = '0;

      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      check("reset_uo", uo_out, 8'h00);
      check("reset_uio", uio_out, 8'h00);
      check("reset_oe", uio_oe, 8'h4F);
      run(17);
      check("pc_wrap", uio_out, 8'h01);

      load(PROG_A, 5);
      run(5);
      check("a_uo", uo_out, 8'h0A);
      check("a_uio", uio_out, 8'h44);
      run(3);
      check("a_hold", uio_out, 8'h44);

      load(PROG_CD, 9);
      last = uo_out;
      repeat (40) begin
         run(1);
         if (uo_out !== last) begin
            seq.push_back(uo_out);
            last = uo_out;
         end
      end
      check("cd_len", 8'(seq.size()), 8'd4);
      if (seq.size() == 4) begin
         check("cd_0", seq[0], 8'h03);
         check("cd_1", seq[1], 8'h02);
         check("cd_2", seq[2], 8'h01);
         check("cd_3", seq[3], 8'h00);
      end
      check("cd_uio", uio_out, 8'h48);

      load(PROG_CY, 12);
      run(30);
      check("carry_uo", uo_out, 8'h0E);
      check("carry_uio", uio_out, 8'h4B);

      load(PROG_CD, 9);
      run(8);
      check("frz_pre_uo", uo_out, 8'h02);
      repeat (5) cycle(1'b1, 1'b1, 1'b0, 8'h00);
      check("frz_uio", uio_out, 8'h04);
      load(PROG_A, 5);
      run(5);
      check("reload_uo", uo_out, 8'h0A);
      check("reload_uio", uio_out, 8'h44);

      cycle(1'b1, 1'b1, 1'b0, 8'h00);
      cycle(1'b1, 1'b1, 1'b1, 8'h77);
      cycle(1'b1, 1'b1, 1'b0, 8'h88);
      cycle(1'b1, 1'b1, 1'b1, 8'h88);
      cycle(1'b1, 1'b1, 1'b0, 8'hF0);
      cycle(1'b0, 1'b1, 1'b1, 8'hF0);
      repeat (3) cycle(1'b1, 1'b1, 1'b1, 8'hF0);
      check("rstld_uo", uo_out, 8'h00);
      check("rstld_uio", uio_out, 8'h00);
      cycle(1'b1, 1'b1, 1'b0, 8'h00);
      cycle(1'b1, 1'b0, 1'b0, 8'h00);
      run(3);
      check("rstld_pc", uio_out, 8'h03);
      load(PROG_A, 5);
      run(5);
      check("rstld_a_uo", uo_out, 8'h0A);

      for (int it = 0; it < 30; it++) begin
         for (int k = 0; k < 16; k++) rp[8*k +: 8] = 8'($urandom);
         load(rp, $urandom_range(1, 16));
         run($urandom_range(5, 50));
      end
      p = 1'b0;
      repeat (400) begin
         if ($urandom_range(0, 9) == 0) p = ~p;
         cycle(($urandom_range(0, 59) != 0), p, 1'($urandom), 8'($urandom));
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
